// File: rtl/dma_2d_pkg.sv
// Shared types and constants for the 2D burst planner: beat size, 4KB page size,
// FSM state encoding and the command record layout.
package dma_2d_pkg;

   localparam int DEF_ADDR_WIDTH = 32;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int BYTES_PER_BEAT = DEF_DATA_WIDTH / 8;
   localparam int AXI_4KB        = 4096;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      ISSUE,
      DONE
   } state_e;

   typedef struct packed {
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [7:0]                len;
      logic                      row_last;
      logic                      last;
   } cmd_t;

endpackage

// File: rtl/dma_2d_burst_len_calc.sv
// Combinational burst length: min of remaining row beats, max burst length and,
// when DMA2D_4K_SPLIT_EN is defined, the beats left before the next 4KB page.
module dma_2d_burst_len_calc
   import dma_2d_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_WIDTH,
   parameter int BPB       = BYTES_PER_BEAT,
   parameter int BURST_LEN = 16
) (
   input  logic [31:0]       row_remaining_i,
   input  logic [ADDR_W-1:0] cur_addr_i,
   output logic [8:0]        len_beats_o
);

   localparam int BPB_SHIFT = $clog2(BPB);

   logic [31:0] limit;
   logic        unused_bits;

`ifdef DMA2D_4K_SPLIT_EN
   logic [12:0] bytes_to_4k;
   logic [31:0] beats_to_4k;

   // Page offset 0 yields the full 4096 bytes, hence the 13-bit subtraction.
   assign bytes_to_4k = 13'(AXI_4KB) - {1'b0, cur_addr_i[11:0]};
   assign beats_to_4k = 32'(bytes_to_4k >> BPB_SHIFT);
`endif

   always_comb begin
      limit = 32'(BURST_LEN);
      if (row_remaining_i < limit) begin
         limit = row_remaining_i;
      end
`ifdef DMA2D_4K_SPLIT_EN
      if (beats_to_4k < limit) begin
         limit = beats_to_4k;
      end
`endif
   end

   assign len_beats_o = limit[8:0];
   assign unused_bits = ^{cur_addr_i, limit[31:9]};

endmodule

// File: rtl/dma_2d_burst_planner.sv
// Splits a 2D image into AXI4 read-burst commands ({addr,len}) over valid/ready.
// Optional 4KB boundary splitting is enabled by defining DMA2D_4K_SPLIT_EN.
module dma_2d_burst_planner
   import dma_2d_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int C_M_AXI_DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int C_M_AXI_BURST_LEN  = 16
) (
   input  logic                          M_AXI_ACLK,
   input  logic                          M_AXI_ARESETN,
   input  logic                          i_start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_src_addr,
   input  logic [31:0]                   i_img_width,
   input  logic [31:0]                   i_img_height,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_img_stride,
   output logic                          o_cmd_valid,
   input  logic                          i_cmd_ready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0] o_cmd_addr,
   output logic [7:0]                    o_cmd_len,
   output logic                          o_cmd_row_last,
   output logic                          o_cmd_last,
   output logic                          o_busy,
   output logic                          o_done,
   output logic                          o_cfg_err
);

   localparam int AW        = C_M_AXI_ADDR_WIDTH;
   localparam int BPB       = C_M_AXI_DATA_WIDTH / 8;
   localparam int BPB_SHIFT = $clog2(BPB);

   state_e        state_q, state_d;
   logic          start_prev_q;
   logic [AW-1:0] cur_addr_q, cur_addr_d;
   logic [AW-1:0] row_addr_q, row_addr_d;
   logic [AW-1:0] stride_q, stride_d;
   logic [31:0]   width_q, width_d;
   logic [31:0]   height_q, height_d;
   logic [31:0]   row_rem_q, row_rem_d;
   logic [31:0]   row_q, row_d;
   logic [8:0]    len_q, len_d;
   logic          cfg_err_q, cfg_err_d;
   cmd_t          cmd_q, cmd_d;

   logic          start_rise;
   logic          cfg_bad;
   logic          row_end;
   logic [8:0]    len_beats;

   dma_2d_burst_len_calc #(
      .ADDR_W    (AW),
      .BPB       (BPB),
      .BURST_LEN (C_M_AXI_BURST_LEN)
   ) u_len_calc (
      .row_remaining_i (row_rem_q),
      .cur_addr_i      (cur_addr_q),
      .len_beats_o     (len_beats)
   );

   assign start_rise = i_start & ~start_prev_q;
   assign cfg_bad    = (i_img_width == 32'd0) || (i_img_height == 32'd0)
                    || ((i_src_addr & AW'(BPB - 1)) != '0)
                    || ((i_img_stride & AW'(BPB - 1)) != '0);

   always_comb begin
      state_d    = state_q;
      cur_addr_d = cur_addr_q;
      row_addr_d = row_addr_q;
      stride_d   = stride_q;
      width_d    = width_q;
      height_d   = height_q;
      row_rem_d  = row_rem_q;
      row_d      = row_q;
      len_d      = len_q;
      cfg_err_d  = cfg_err_q;
      cmd_d      = cmd_q;
      row_end    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_rise) begin
               cfg_err_d  = cfg_bad;
               cur_addr_d = i_src_addr;
               row_addr_d = i_src_addr;
               stride_d   = i_img_stride;
               width_d    = i_img_width;
               height_d   = i_img_height;
               row_rem_d  = i_img_width;
               row_d      = 32'd0;
               state_d    = cfg_bad ? DONE : CALC;
            end
         end
         CALC: begin
            row_end        = (32'(len_beats) == row_rem_q);
            len_d          = len_beats;
            cmd_d.addr     = cur_addr_q;
            cmd_d.len      = 8'(len_beats - 9'd1);
            cmd_d.row_last = row_end;
            cmd_d.last     = row_end && (row_q == height_q - 32'd1);
            state_d        = ISSUE;
         end
         ISSUE: begin
            if (i_cmd_ready) begin
               if (32'(len_q) == row_rem_q) begin
                  // Row finished: jump to the next row start, not past the burst.
                  row_addr_d = row_addr_q + stride_q;
                  cur_addr_d = row_addr_q + stride_q;
                  row_rem_d  = width_q;
                  row_d      = row_q + 32'd1;
               end else begin
                  cur_addr_d = cur_addr_q + (AW'(len_q) << BPB_SHIFT);
                  row_rem_d  = row_rem_q - 32'(len_q);
               end
               state_d = cmd_q.last ? DONE : CALC;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge M_AXI_ACLK) begin
      if (!M_AXI_ARESETN) begin
         state_q      <= IDLE;
         start_prev_q <= 1'b0;
         cur_addr_q   <= '0;
         row_addr_q   <= '0;
         stride_q     <= '0;
         width_q      <= '0;
         height_q     <= '0;
         row_rem_q    <= '0;
         row_q        <= '0;
         len_q        <= '0;
         cfg_err_q    <= 1'b0;
         cmd_q        <= '0;
      end else begin
         state_q      <= state_d;
         start_prev_q <= i_start;
         cur_addr_q   <= cur_addr_d;
         row_addr_q   <= row_addr_d;
         stride_q     <= stride_d;
         width_q      <= width_d;
         height_q     <= height_d;
         row_rem_q    <= row_rem_d;
         row_q        <= row_d;
         len_q        <= len_d;
         cfg_err_q    <= cfg_err_d;
         cmd_q        <= cmd_d;
      end
   end

   assign o_cmd_valid    = (state_q == ISSUE);
   assign o_busy         = (state_q == CALC) || (state_q == ISSUE);
   assign o_done         = (state_q == DONE);
   assign o_cfg_err      = cfg_err_q;
   assign o_cmd_addr     = cmd_q.addr;
   assign o_cmd_len      = cmd_q.len;
   assign o_cmd_row_last = cmd_q.row_last;
   assign o_cmd_last     = cmd_q.last;

endmodule

// File: tb/tb_dma_2d_burst_planner.sv
// Scoreboard bench for dma_2d_burst_planner: directed frames push expected commands
// and done events; a negedge monitor pops and compares on each handshake/done.
module tb_dma_2d_burst_planner;
   import dma_2d_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [31:0] i_src_addr = '0;
   logic [31:0] i_img_width = '0;
   logic [31:0] i_img_height = '0;
   logic [31:0] i_img_stride = '0;
   logic        i_cmd_ready = 1'b1;
   logic        o_cmd_valid;
   logic [31:0] o_cmd_addr;
   logic [7:0]  o_cmd_len;
   logic        o_cmd_row_last;
   logic        o_cmd_last;
   logic        o_busy;
   logic        o_done;
   logic        o_cfg_err;

   always #5 clk = ~clk;

   dma_2d_burst_planner dut (
      .M_AXI_ACLK     (clk),
      .M_AXI_ARESETN  (rst_n),
      .i_start        (i_start),
      .i_src_addr     (i_src_addr),
      .i_img_width    (i_img_width),
      .i_img_height   (i_img_height),
      .i_img_stride   (i_img_stride),
      .o_cmd_valid    (o_cmd_valid),
      .i_cmd_ready    (i_cmd_ready),
      .o_cmd_addr     (o_cmd_addr),
      .o_cmd_len      (o_cmd_len),
      .o_cmd_row_last (o_cmd_row_last),
      .o_cmd_last     (o_cmd_last),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_cfg_err      (o_cfg_err)
   );

   cmd_t exp_q[$];
   bit   done_q[$];   // 1 = done expected from a config error
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   last_hs_cyc = -10;
   int   hs_cnt = 0;
   int   done_cnt = 0;
   bit   first_pending = 1'b0;
   bit   prev_stall = 1'b0;
   cmd_t prev_cmd;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input string detail);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   task automatic push(input logic [31:0] a, input int l, input bit rl, input bit la);
      cmd_t c;
      c.addr = a;
      c.len = 8'(l);
      c.row_last = rl;
      c.last = la;
      exp_q.push_back(c);
   endtask

   task automatic push_t1();
      push(32'h1000_0000, 15, 0, 0);
      push(32'h1000_0040, 15, 0, 0);
      push(32'h1000_0080, 7, 1, 0);
      push(32'h1000_0200, 15, 0, 0);
      push(32'h1000_0240, 15, 0, 0);
      push(32'h1000_0280, 7, 1, 1);
      done_q.push_back(1'b0);
   endtask

   task automatic start_frame(input logic [31:0] src, input logic [31:0] w, input logic [31:0] h,
                              input logic [31:0] stride, input bit good, input bit hold);
      @(posedge clk); #1;
      i_src_addr = src;
      i_img_width = w;
      i_img_height = h;
      i_img_stride = stride;
      i_start = 1'b1;
      start_cyc = cyc;
      first_pending = good;
      @(posedge clk); #1;
      if (!hold) i_start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int base = done_cnt;
      int n = 0;
      while (done_cnt == base && n < budget) begin
         @(posedge clk);
         n++;
      end
      check(done_cnt != base, "done_timeout", $sformatf("done count %0d, required > %0d", done_cnt, base));
   endtask

   task automatic wait_hs(input int target, input int budget);
      int n = 0;
      while (hs_cnt < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      check(hs_cnt >= target, "hs_timeout", $sformatf("handshakes %0d, required %0d", hs_cnt, target));
   endtask

   // Monitor: compares every handshake and done pulse against the scoreboard.
   always @(negedge clk) begin
      cmd_t cur;
      cmd_t e;
      bit   d;
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         cur.addr = o_cmd_addr;
         cur.len = o_cmd_len;
         cur.row_last = o_cmd_row_last;
         cur.last = o_cmd_last;
         if (prev_stall)
            check(o_cmd_valid && cur == prev_cmd, "hold_stable",
                  $sformatf("valid %0b cmd %h, required valid 1 cmd %h", o_cmd_valid, cur, prev_cmd));
         if (o_cmd_valid && first_pending) begin
            check(cyc == start_cyc + 2 && o_busy && !o_cfg_err, "first_cmd",
                  $sformatf("cycle %0d busy %0b cfg_err %0b, required cycle %0d busy 1 cfg_err 0",
                            cyc, o_busy, o_cfg_err, start_cyc + 2));
            first_pending = 1'b0;
         end
         if (o_cmd_valid && i_cmd_ready) begin
            if (exp_q.size() == 0) begin
               check(1'b0, "unexpected_cmd", $sformatf("got %h, required none", cur));
            end else begin
               e = exp_q.pop_front();
               check(cur == e, "cmd", $sformatf("addr %h len %0d rl %0b last %0b, required addr %h len %0d rl %0b last %0b",
                     cur.addr, cur.len, cur.row_last, cur.last, e.addr, e.len, e.row_last, e.last));
            end
            hs_cnt++;
            if (o_cmd_last) last_hs_cyc = cyc;
         end
         if (o_done) begin
            done_cnt++;
            if (done_q.size() == 0) begin
               check(1'b0, "unexpected_done", $sformatf("done at cycle %0d, required none", cyc));
            end else begin
               d = done_q.pop_front();
               if (d)
                  check(o_cfg_err && !o_busy && cyc == start_cyc + 1, "err_done",
                        $sformatf("cfg_err %0b busy %0b cycle %0d, required 1 0 %0d", o_cfg_err, o_busy, cyc, start_cyc + 1));
               else
                  check(!o_cfg_err && !o_busy && cyc == last_hs_cyc + 1, "done",
                        $sformatf("cfg_err %0b busy %0b cycle %0d, required 0 0 %0d", o_cfg_err, o_busy, cyc, last_hs_cyc + 1));
            end
         end
         prev_stall = o_cmd_valid && !i_cmd_ready;
         prev_cmd = cur;
      end
   end

   initial begin
      int base;
      repeat (3) @(posedge clk);
      #1;
      check({o_cmd_valid, o_cmd_addr, o_cmd_len, o_cmd_row_last, o_cmd_last, o_busy, o_done, o_cfg_err} == '0,
            "reset_outputs", $sformatf("valid %0b addr %h busy %0b done %0b err %0b, required all 0",
            o_cmd_valid, o_cmd_addr, o_busy, o_done, o_cfg_err));
      rst_n = 1'b1;

      // T1: two rows of 40 beats
      push_t1();
      start_frame(32'h1000_0000, 40, 2, 32'h200, 1, 0);
      wait_done(200);

      // T2: start held high across the whole frame must not retrigger
`ifdef DMA2D_4K_SPLIT_EN
      push(32'h1000_0FF0, 3, 1'b0, 1'b0);
      push(32'h1000_1000, 11, 1'b1, 1'b1);
`else
      push(32'h1000_0FF0, 15, 1'b1, 1'b1);
`endif
      done_q.push_back(1'b0);
      start_frame(32'h1000_0FF0, 16, 1, 32'h100, 1, 1);
      wait_done(200);
      repeat (6) @(posedge clk);
      #1 i_start = 1'b0;

      // T3: zero height, then misaligned source
      done_q.push_back(1'b1);
      start_frame(32'h1000_0000, 16, 0, 32'h100, 0, 0);
      wait_done(50);
      done_q.push_back(1'b1);
      start_frame(32'h1000_0002, 16, 1, 32'h100, 0, 0);
      wait_done(50);

      // T4: backpressure on the second command
      push_t1();
      base = hs_cnt;
      start_frame(32'h1000_0000, 40, 2, 32'h200, 1, 0);
      wait_hs(base + 1, 100);
      #1 i_cmd_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1 i_cmd_ready = 1'b1;
      wait_done(200);

      // T5: reset during row 1 aborts without done, then a fresh T1 frame
      push_t1();
      base = hs_cnt;
      start_frame(32'h1000_0000, 40, 2, 32'h200, 1, 0);
      wait_hs(base + 4, 100);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      check({o_cmd_valid, o_cmd_addr, o_cmd_len, o_cmd_row_last, o_cmd_last, o_busy, o_done, o_cfg_err} == '0,
            "abort_outputs", $sformatf("valid %0b addr %h busy %0b done %0b, required all 0",
            o_cmd_valid, o_cmd_addr, o_busy, o_done));
      exp_q.delete();
      done_q.delete();
      first_pending = 1'b0;
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      push_t1();
      start_frame(32'h1000_0000, 40, 2, 32'h200, 1, 0);
      wait_done(200);

      // T6: address wraps past 2^32
      push(32'hFFFF_FFC0, 15, 1'b0, 1'b0);
      push(32'h0000_0000, 15, 1'b1, 1'b1);
      done_q.push_back(1'b0);
      start_frame(32'hFFFF_FFC0, 32, 1, 32'h100, 1, 0);
      wait_done(200);

      repeat (4) @(posedge clk);
      #1;
      check(exp_q.size() == 0 && done_q.size() == 0, "queues_empty",
            $sformatf("cmd left %0d done left %0d, required 0 0", exp_q.size(), done_q.size()));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
